// File: rtl/instr_issue_unit_pkg.sv
// Shared definitions for the instruction issue path:
// FSM states, legal opcodes and Funct field positions.
package instr_issue_unit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT_BR,
    S_HALT
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int FUNCT_HI     = 30;
  localparam int FUNCT_LO_MSB = 14;
  localparam int FUNCT_LO_LSB = 12;

  function automatic logic op_legal(
    input logic [6:0] op
  );
    return (op == OP_RTYPE) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic [3:0] funct_of(
    input logic [31:0] w
  );
    return {w[FUNCT_HI], w[FUNCT_LO_MSB:FUNCT_LO_LSB]};
  endfunction

endpackage

// File: rtl/instr_issue_unit_branch_target_calc.sv
// Branch target: B-type immediate, taken/not-taken
// target selection and word-alignment check.
module branch_target_calc (
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic        taken,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [12:0] imm13;
  logic [31:0] immb;
  logic        unused_ir;

  assign imm13 = {ir[31], ir[7], ir[30:25],
                  ir[11:8], 1'b0};
  assign immb  = {{19{imm13[12]}}, imm13};

  // Modulo-2^32 wrap comes for free from the 32-bit add.
  assign target = taken ? (pc + immb) : (pc + 32'd4);
  assign misaligned = (target[1:0] != 2'b00);

  assign unused_ir = ^{ir[24:12], ir[6:0]};

endmodule

// File: rtl/instr_issue_unit.sv
// Fetch/issue sequencer: fetches one word, issues its
// opcode/funct, waits for branch resolution, updates PC.
module instr_issue_unit
  import instr_issue_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [6:0]  Opcode,
  output logic [3:0]  Funct,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic [31:0] pc_out,
  output logic        halted
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] br_target;
  logic        br_misalign;
  logic        is_branch;

  branch_target_calc u_btc (
    .pc         (pc),
    .ir         (ir),
    .taken      (br_taken),
    .target     (br_target),
    .misaligned (br_misalign)
  );

  assign is_branch = (ir[6:0] == OP_BRANCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state    <= S_FETCH;
            imem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= op_legal(imem_rdata[6:0]);
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // valid low here means the captured word was illegal
          if (!instr_valid) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (is_branch) begin
              state <= S_WAIT_BR;
            end else begin
              pc       <= pc + 32'd4;
              state    <= run ? S_FETCH : S_IDLE;
              imem_req <= run;
            end
          end
        end
        S_WAIT_BR: begin
          if (br_valid) begin
            if (br_misalign) begin
              state  <= S_HALT;
              halted <= 1'b1;
            end else begin
              pc       <= br_target;
              state    <= run ? S_FETCH : S_IDLE;
              imem_req <= run;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign Opcode    = instr_valid ? ir[6:0] : 7'd0;
  assign Funct     = instr_valid ? funct_of(ir) : 4'd0;
  assign imem_addr = pc;
  assign pc_out    = pc;

endmodule
